// File: rtl/retire_mon_pkg.sv
// Shared constants for the retire monitor: FSM state encoding and error codes.
package retire_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_HALTED  = 3'd2,
    ST_TRAPPED = 3'd3,
    ST_ERROR   = 3'd4
  } monState_e;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_FIRST_PC = 3'd1;
  localparam logic [2:0] ERR_PC_DISC  = 3'd2;
  localparam logic [2:0] ERR_X0_READ  = 3'd3;
  localparam logic [2:0] ERR_MISALIGN = 3'd4;
  localparam logic [2:0] ERR_SHADOW   = 3'd5;

  function automatic logic isTerminal(input monState_e s);
    return (s == ST_HALTED) || (s == ST_TRAPPED) || (s == ST_ERROR);
  endfunction

endpackage

// File: rtl/retire_mon_shadow_rf.sv
// Shadow register file x1..x31 mirroring retired writes; x0 always reads as zero.
module retire_mon_shadow_rf (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr1,
  output logic [31:0] o_rdata1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata2
);

  logic [31:0] regs_q [1:31];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (i_we && (i_waddr != 5'd0)) begin
      regs_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 : regs_q[i_raddr1];
  assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 : regs_q[i_raddr2];

endmodule

// File: rtl/retire_monitor.sv
// Retire-bus monitor: checks PC flow and x0 reads, counts retires and cycles.
// Define RETIRE_MON_SHADOW_EN to add shadow register-file checking (code 5).
module retire_monitor
  import retire_mon_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h00000000,
  parameter int          CNT_W      = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_retire_valid,
  input  logic             i_retire_trap,
  input  logic             i_retire_halt,
  input  logic [31:0]      i_retire_inst,
  input  logic [31:0]      i_retire_pc,
  input  logic [31:0]      i_retire_next_pc,
  input  logic [4:0]       i_retire_rs1_raddr,
  input  logic [4:0]       i_retire_rs2_raddr,
  input  logic [4:0]       i_retire_rd_waddr,
  input  logic [31:0]      i_retire_rs1_rdata,
  input  logic [31:0]      i_retire_rs2_rdata,
  input  logic [31:0]      i_retire_rd_wdata,
  output logic [CNT_W-1:0] o_retire_count,
  output logic [CNT_W-1:0] o_cycle_count,
  output logic [2:0]       o_state,
  output logic             o_done,
  output logic [2:0]       o_err_code,
  output logic [31:0]      o_err_pc
);

  monState_e        state_q;
  logic [CNT_W-1:0] retireCnt_q;
  logic [CNT_W-1:0] cycleCnt_q;
  logic [2:0]       errCode_q;
  logic [2:0]       errCode_d;
  logic [31:0]      errPc_q;
  logic [31:0]      expPc_q;
  logic             done_q;
  logic             checked;
  logic             x0Bad;
  logic             shadowBad;

  assign checked = i_retire_valid && !isTerminal(state_q);
  assign x0Bad   = ((i_retire_rs1_raddr == 5'd0) && (i_retire_rs1_rdata != 32'd0)) ||
                   ((i_retire_rs2_raddr == 5'd0) && (i_retire_rs2_rdata != 32'd0));

`ifdef RETIRE_MON_SHADOW_EN
  logic [31:0] shadowRs1Data;
  logic [31:0] shadowRs2Data;
  logic        unusedBits;

  retire_mon_shadow_rf u_shadow (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_we     (checked && !i_retire_trap),
    .i_waddr  (i_retire_rd_waddr),
    .i_wdata  (i_retire_rd_wdata),
    .i_raddr1 (i_retire_rs1_raddr),
    .o_rdata1 (shadowRs1Data),
    .i_raddr2 (i_retire_rs2_raddr),
    .o_rdata2 (shadowRs2Data)
  );

  // Reads see the pre-write value, matching an instruction reading and writing the same register.
  assign shadowBad = ((i_retire_rs1_raddr != 5'd0) && (i_retire_rs1_rdata != shadowRs1Data)) ||
                     ((i_retire_rs2_raddr != 5'd0) && (i_retire_rs2_rdata != shadowRs2Data));
  assign unusedBits = ^i_retire_inst;
`else
  logic unusedBits;

  assign shadowBad  = 1'b0;
  assign unusedBits = ^{i_retire_inst, i_retire_rd_waddr, i_retire_rd_wdata};
`endif

  // Lowest-numbered code wins; expPc_q still holds RESET_ADDR while in IDLE.
  always_comb begin
    errCode_d = ERR_NONE;
    if (i_retire_pc != expPc_q) begin
      errCode_d = (state_q == ST_IDLE) ? ERR_FIRST_PC : ERR_PC_DISC;
    end else if (x0Bad) begin
      errCode_d = ERR_X0_READ;
    end else if ((i_retire_pc[1:0] != 2'b00) && !i_retire_trap) begin
      errCode_d = ERR_MISALIGN;
    end else if (shadowBad) begin
      errCode_d = ERR_SHADOW;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      retireCnt_q <= '0;
      cycleCnt_q  <= '0;
      errCode_q   <= ERR_NONE;
      errPc_q     <= 32'd0;
      expPc_q     <= RESET_ADDR;
      done_q      <= 1'b0;
    end else if (!isTerminal(state_q)) begin
      if (cycleCnt_q != '1) begin
        cycleCnt_q <= cycleCnt_q + CNT_W'(1);
      end
      if (i_retire_valid) begin
        if (retireCnt_q != '1) begin
          retireCnt_q <= retireCnt_q + CNT_W'(1);
        end
        expPc_q <= i_retire_next_pc;
        if (errCode_d != ERR_NONE) begin
          state_q   <= ST_ERROR;
          errCode_q <= errCode_d;
          errPc_q   <= i_retire_pc;
          done_q    <= 1'b1;
        end else if (i_retire_trap) begin
          state_q <= ST_TRAPPED;
          done_q  <= 1'b1;
        end else if (i_retire_halt) begin
          state_q <= ST_HALTED;
          done_q  <= 1'b1;
        end else begin
          state_q <= ST_RUN;
        end
      end
    end
  end

  assign o_retire_count = retireCnt_q;
  assign o_cycle_count  = cycleCnt_q;
  assign o_state        = state_q;
  assign o_done         = done_q;
  assign o_err_code     = errCode_q;
  assign o_err_pc       = errPc_q;

endmodule

// File: tb/tb_retire_monitor.sv
// Directed testbench for retire_monitor: default-width instance plus a 4-bit counter instance.
module tb_retire_monitor;

  logic        clk = 1'b0;
  logic        rstN;
  logic        valid, trap, halt;
  logic [31:0] inst, pc, nextPc;
  logic [4:0]  rs1A, rs2A, rdA;
  logic [31:0] rs1D, rs2D, rdD;

  logic [31:0] retireCnt, cycleCnt, errPc;
  logic [2:0]  state, errCode;
  logic        done;

  logic [3:0]  satRetireCnt, satCycleCnt;
  logic [2:0]  satState, satErrCode;
  logic        satDone;
  logic [31:0] satErrPc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  retire_monitor dut (
    .i_clk(clk), .i_rst_n(rstN),
    .i_retire_valid(valid), .i_retire_trap(trap), .i_retire_halt(halt),
    .i_retire_inst(inst), .i_retire_pc(pc), .i_retire_next_pc(nextPc),
    .i_retire_rs1_raddr(rs1A), .i_retire_rs2_raddr(rs2A), .i_retire_rd_waddr(rdA),
    .i_retire_rs1_rdata(rs1D), .i_retire_rs2_rdata(rs2D), .i_retire_rd_wdata(rdD),
    .o_retire_count(retireCnt), .o_cycle_count(cycleCnt), .o_state(state),
    .o_done(done), .o_err_code(errCode), .o_err_pc(errPc)
  );

  retire_monitor #(.CNT_W(4)) dutSat (
    .i_clk(clk), .i_rst_n(rstN),
    .i_retire_valid(valid), .i_retire_trap(trap), .i_retire_halt(halt),
    .i_retire_inst(inst), .i_retire_pc(pc), .i_retire_next_pc(nextPc),
    .i_retire_rs1_raddr(rs1A), .i_retire_rs2_raddr(rs2A), .i_retire_rd_waddr(rdA),
    .i_retire_rs1_rdata(rs1D), .i_retire_rs2_rdata(rs2D), .i_retire_rd_wdata(rdD),
    .o_retire_count(satRetireCnt), .o_cycle_count(satCycleCnt), .o_state(satState),
    .o_done(satDone), .o_err_code(satErrCode), .o_err_pc(satErrPc)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // One valid retire on the next rising edge; outputs are stable 1 time unit later.
  task automatic applyStimulus(input logic [31:0] pcIn, input logic [31:0] nextIn,
                               input logic trapIn = 1'b0, input logic haltIn = 1'b0,
                               input logic [4:0] rs1AIn = 5'd1, input logic [31:0] rs1DIn = 32'd0,
                               input logic [4:0] rdAIn = 5'd0, input logic [31:0] rdDIn = 32'd0);
    valid  = 1'b1;
    pc     = pcIn;
    nextPc = nextIn;
    trap   = trapIn;
    halt   = haltIn;
    rs1A   = rs1AIn;
    rs1D   = rs1DIn;
    rdA    = rdAIn;
    rdD    = rdDIn;
    @(posedge clk);
    #1;
    valid = 1'b0;
    trap  = 1'b0;
    halt  = 1'b0;
  endtask

  // Reset released on a falling edge so the next retire lands on the first counted cycle.
  task automatic resetDut();
    rstN  = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
  endtask

  initial begin
    rstN = 1'b1; valid = 1'b0; trap = 1'b0; halt = 1'b0;
    inst = 32'h00000013; pc = '0; nextPc = '0;
    rs1A = 5'd1; rs2A = 5'd2; rdA = 5'd0;
    rs1D = '0; rs2D = '0; rdD = '0;

    #2 rstN = 1'b0;
    #1;
    checkOutput("reset_state", 32'(state), 32'd0);
    checkOutput("reset_retire", retireCnt, 32'd0);
    checkOutput("reset_cycle", cycleCnt, 32'd0);
    checkOutput("reset_errcode", 32'(errCode), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    rstN = 1'b1;

    // Normal run ending in halt
    applyStimulus(32'h0, 32'h4);
    checkOutput("run_state", 32'(state), 32'd1);
    applyStimulus(32'h4, 32'h8);
    applyStimulus(32'h8, 32'hC);
    applyStimulus(32'hC, 32'h10, 1'b0, 1'b1);
    checkOutput("halt_state", 32'(state), 32'd2);
    checkOutput("halt_retire", retireCnt, 32'd4);
    checkOutput("halt_cycle", cycleCnt, 32'd4);
    checkOutput("halt_errcode", 32'(errCode), 32'd0);
    checkOutput("halt_done", 32'(done), 32'd1);
    applyStimulus(32'h10, 32'h14);
    checkOutput("halt_ignore_retire", retireCnt, 32'd4);
    checkOutput("halt_ignore_cycle", cycleCnt, 32'd4);

    // Bad first PC
    resetDut();
    applyStimulus(32'h10, 32'h14);
    checkOutput("badpc_state", 32'(state), 32'd4);
    checkOutput("badpc_code", 32'(errCode), 32'd1);
    checkOutput("badpc_errpc", errPc, 32'h10);
    checkOutput("badpc_retire", retireCnt, 32'd1);

    // Async clear of a latched error, then discontinuity beating trap
    rstN = 1'b0;
    #1;
    checkOutput("async_errcode", 32'(errCode), 32'd0);
    checkOutput("async_errpc", errPc, 32'd0);
    checkOutput("async_done", 32'(done), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(32'h0, 32'h8);
    applyStimulus(32'h4, 32'h8, 1'b1);
    checkOutput("disc_state", 32'(state), 32'd4);
    checkOutput("disc_code", 32'(errCode), 32'd2);
    checkOutput("disc_errpc", errPc, 32'h4);

    // x0 read with nonzero data, later retires ignored
    resetDut();
    applyStimulus(32'h0, 32'h4, 1'b0, 1'b0, 5'd0, 32'h5);
    checkOutput("x0_code", 32'(errCode), 32'd3);
    applyStimulus(32'h4, 32'h8);
    applyStimulus(32'h8, 32'hC);
    checkOutput("x0_frozen_retire", retireCnt, 32'd1);
    checkOutput("x0_frozen_cycle", cycleCnt, 32'd1);

    // Simultaneous wrong first PC and misalignment: lowest code only
    resetDut();
    applyStimulus(32'h12, 32'h16);
    checkOutput("prio_code", 32'(errCode), 32'd1);

    // Misaligned PC without and with trap
    resetDut();
    applyStimulus(32'h0, 32'h6);
    applyStimulus(32'h6, 32'hA);
    checkOutput("misalign_code", 32'(errCode), 32'd4);
    checkOutput("misalign_errpc", errPc, 32'h6);
    resetDut();
    applyStimulus(32'h0, 32'h6);
    applyStimulus(32'h6, 32'hA, 1'b1);
    checkOutput("trap_state", 32'(state), 32'd3);
    checkOutput("trap_code", 32'(errCode), 32'd0);
    checkOutput("trap_done", 32'(done), 32'd1);

    // Shadow register file: write x5, read back matching then mismatching data
    resetDut();
    applyStimulus(32'h0, 32'h4, 1'b0, 1'b0, 5'd1, 32'd0, 5'd5, 32'hDEAD);
    applyStimulus(32'h4, 32'h8, 1'b0, 1'b0, 5'd5, 32'hDEAD);
    checkOutput("shadow_match_state", 32'(state), 32'd1);
    applyStimulus(32'h8, 32'hC, 1'b0, 1'b0, 5'd5, 32'hBEEF);
`ifdef RETIRE_MON_SHADOW_EN
    checkOutput("shadow_bad_state", 32'(state), 32'd4);
    checkOutput("shadow_bad_code", 32'(errCode), 32'd5);
    checkOutput("shadow_bad_errpc", errPc, 32'h8);
`else
    checkOutput("shadow_off_state", 32'(state), 32'd1);
    checkOutput("shadow_off_code", 32'(errCode), 32'd0);
`endif

    // Counter saturation on the 4-bit instance, then mid-run async reset
    resetDut();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(32'(4 * i), 32'(4 * i + 4));
    end
    checkOutput("sat_retire", 32'(satRetireCnt), 32'd15);
    checkOutput("sat_cycle", 32'(satCycleCnt), 32'd15);
    checkOutput("sat_state", 32'(satState), 32'd1);
    checkOutput("wide_retire", retireCnt, 32'd20);
    rstN = 1'b0;
    #2;
    checkOutput("midrst_sat_retire", 32'(satRetireCnt), 32'd0);
    checkOutput("midrst_sat_cycle", 32'(satCycleCnt), 32'd0);
    checkOutput("midrst_state", 32'(state), 32'd0);
    checkOutput("midrst_retire", retireCnt, 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(32'h0, 32'h4);
    checkOutput("after_rst_retire", 32'(satRetireCnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
